mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage consumer of the EX-stage result bus: registers EX_alu_res/EX_mem_din/EX_vld, performs
//  byte/half/word loads and stores on a req/ack data-memory port, and returns aligned, extended load
//  data as MEM_data (the forwarding source fed back to EX). Stalls upstream via MEM_busy while a
//  memory access is outstanding. Sits between ex_stage and the writeback stage.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles in WAIT before bus error (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk              in   1   single clock; rising edge
//  rst              in   1   reset is asynchronous and active-low
//  EX_alu_res       in   32  ALU result / effective address
//  EX_mem_din       in   32  store data (rs2, already forwarded)
//  EX_vld           in   1   EX result valid
//  EX_mem_rd        in   1   load
//  EX_mem_wr        in   1   store
//  EX_mem_size      in   2   00 byte, 01 half, 10 word, 11 reserved
//  EX_mem_unsigned  in   1   zero-extend load (LBU/LHU)
//  MEM_data         out  32  registered result: load data or passthrough ALU result
//  MEM_vld          out  1   MEM_data valid, one-cycle pulse per retired op
//  MEM_busy         out  1   upstream must hold EX outputs stable
//  MEM_misaligned   out  1   one-cycle pulse: misaligned/illegal access dropped
//  MEM_bus_err      out  1   one-cycle pulse: access timed out (0 without MEM_TIMEOUT_EN)
//  dmem_req         out  1   request; held high until dmem_ack
//  dmem_we          out  1   1=write
//  dmem_addr        out  32  {addr[31:2],2'b00}, stable while dmem_req
//  dmem_be          out  4   byte enables
//  dmem_wdata       out  32  lane-replicated store data
//  dmem_rdata       in   32  read data, valid with dmem_ack
//  dmem_ack         in   1   access complete; ignored when dmem_req=0
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0 incl. MEM_data=0, dmem_req=0. Reset mid-access
//   drops dmem_req immediately; access abandoned, no MEM_vld.
//  FSM IDLE -> WAIT on valid aligned mem op; WAIT -> IDLE on dmem_ack (or timeout). MEM_busy=(state==WAIT).
//  IDLE, EX_vld=0: MEM_vld<=0, MEM_data holds.
//  IDLE, EX_vld=1, no rd/wr: MEM_data<=EX_alu_res, MEM_vld<=1 next cycle (latency 1).
//  IDLE, EX_vld=1, rd xor wr, aligned: latch addr/size/unsigned/we, be, wdata; WAIT; dmem_req=1 next cycle.
//  Alignment: half needs addr[0]=0, word needs addr[1:0]=0. Misaligned, size=11, or rd&wr both set:
//   no request, MEM_misaligned<=1 one cycle, MEM_vld<=0, MEM_data holds.
//  be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
//  wdata: byte {4{din[7:0]}}; half {2{din[15:0]}}; word din.
//  WAIT: EX inputs ignored (no capture). On edge with dmem_ack=1: dmem_req<=0, state IDLE, MEM_vld<=1;
//   load: MEM_data<=ext(dmem_rdata>>(8*addr[1:0])), sign- or zero-extend from bit 7/15;
//   store: MEM_data<=address. Earliest ack is the first req cycle -> load latency 2 from capture.
//  Ack-cycle EX values are captured one cycle later (one bubble after each mem op).
//  dmem_req/we/addr/be/wdata registered and stable from request through ack cycle inclusive.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: counter cleared on WAIT entry, incremented each WAIT cycle without ack;
//   reaching TIMEOUT_CYCLES -> dmem_req<=0, IDLE, MEM_bus_err pulse 1 cycle, MEM_vld=0, MEM_data holds.
//   Ack in the same cycle as expiry wins (normal completion).
//  Not defined: WAIT persists until ack; no counter logic; MEM_bus_err tied 0.
// TESTING
//  ALU passthrough: EX_vld=1, alu_res=32'h1234_5678, rd=wr=0 -> next cycle MEM_data=32'h1234_5678, MEM_vld=1, no req.
//  LB sign: addr=0x103, size=00, rdata=0x80AA_BBCC, ack 1st req cycle -> be=4'b1000, MEM_data=0xFFFF_FF80 at +2.
//  LHU: addr=0x102, unsigned, rdata=0xBEEF_0000, ack after 3 cycles -> MEM_busy high 4 cycles, MEM_data=0x0000_BEEF.
//  SB: addr=0x101, din=0xDEAD_BEA5 -> dmem_we=1, be=4'b0010, wdata=0xA5A5_A5A5, addr=0x100, MEM_vld on ack.
//  Misaligned LW addr=0x102 -> no dmem_req, MEM_misaligned=1 one cycle, MEM_data unchanged, MEM_busy=0.
//  Reset mid-WAIT: rst low with dmem_req=1 -> dmem_req=0 same cycle, all outputs 0; with MEM_TIMEOUT_EN
//   and no ack, MEM_bus_err pulses after TIMEOUT_CYCLES.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit on a req/ack data port; optional MEM_TIMEOUT_EN bus timeout
module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_alu_res,
    input  logic [31:0] EX_mem_din,
    input  logic        EX_vld,
    input  logic        EX_mem_rd,
    input  logic        EX_mem_wr,
    input  logic [1:0]  EX_mem_size,
    input  logic        EX_mem_unsigned,
    output logic [31:0] MEM_data,
    output logic        MEM_vld,
    output logic        MEM_busy,
    output logic        MEM_misaligned,
    output logic        MEM_bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state, state_nxt;
    logic [1:0]  lat_off;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic        mem_op, illegal, start, timeout;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] shifted, load_ext;

    assign mem_op   = EX_mem_rd | EX_mem_wr;
    assign MEM_busy = (state == S_WAIT);

    // Anything that cannot be issued as a single aligned access is dropped here.
    always_comb begin
        illegal = EX_mem_rd & EX_mem_wr;
        case (EX_mem_size)
            2'b00:   illegal = illegal;
            2'b01:   illegal = illegal | EX_alu_res[0];
            2'b10:   illegal = illegal | (EX_alu_res[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    assign start = (state == S_IDLE) && EX_vld && mem_op && !illegal;

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = EX_mem_din;
        case (EX_mem_size)
            2'b00: begin
                be_nxt    = 4'b0001 << EX_alu_res[1:0];
                wdata_nxt = {4{EX_mem_din[7:0]}};
            end
            2'b01: begin
                be_nxt    = 4'b0011 << {EX_alu_res[1], 1'b0};
                wdata_nxt = {2{EX_mem_din[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = EX_mem_din;
            end
        endcase
    end

    assign shifted = dmem_rdata >> {lat_off, 3'b000};

    always_comb begin
        case (lat_size)
            2'b00:   load_ext = {{24{~lat_uns & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{~lat_uns & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // An ack on the expiry cycle takes priority, so timeout requires !dmem_ack.
    assign timeout = (state == S_WAIT) && !dmem_ack && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tmo_cnt <= '0;
        else if (state == S_IDLE)
            tmo_cnt <= '0;
        else if (!dmem_ack)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_WAIT;
            S_WAIT: if (dmem_ack || timeout) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MEM_data       <= '0;
            MEM_vld        <= 1'b0;
            MEM_misaligned <= 1'b0;
            MEM_bus_err    <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_be        <= '0;
            dmem_wdata     <= '0;
            lat_off        <= '0;
            lat_size       <= '0;
            lat_uns        <= 1'b0;
        end else begin
            MEM_vld        <= 1'b0;
            MEM_misaligned <= 1'b0;
            MEM_bus_err    <= 1'b0;
            if (state == S_IDLE) begin
                if (EX_vld && !mem_op) begin
                    MEM_data <= EX_alu_res;
                    MEM_vld  <= 1'b1;
                end else if (EX_vld && illegal) begin
                    MEM_misaligned <= 1'b1;
                end else if (start) begin
                    dmem_req   <= 1'b1;
                    dmem_we    <= EX_mem_wr;
                    dmem_addr  <= {EX_alu_res[31:2], 2'b00};
                    dmem_be    <= be_nxt;
                    dmem_wdata <= wdata_nxt;
                    lat_off    <= EX_alu_res[1:0];
                    lat_size   <= EX_mem_size;
                    lat_uns    <= EX_mem_unsigned;
                end
            end else if (dmem_ack) begin
                dmem_req <= 1'b0;
                MEM_vld  <= 1'b1;
                MEM_data <= dmem_we ? {dmem_addr[31:2], lat_off} : load_ext;
            end else if (timeout) begin
                dmem_req    <= 1'b0;
                MEM_bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] EX_alu_res = '0;
    logic [31:0] EX_mem_din = '0;
    logic        EX_vld = 1'b0;
    logic        EX_mem_rd = 1'b0;
    logic        EX_mem_wr = 1'b0;
    logic [1:0]  EX_mem_size = '0;
    logic        EX_mem_unsigned = 1'b0;
    logic [31:0] MEM_data;
    logic        MEM_vld, MEM_busy, MEM_misaligned, MEM_bus_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;

    int tests = 0;
    int fails = 0;
    int busy_cnt;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .EX_alu_res(EX_alu_res), .EX_mem_din(EX_mem_din), .EX_vld(EX_vld),
        .EX_mem_rd(EX_mem_rd), .EX_mem_wr(EX_mem_wr), .EX_mem_size(EX_mem_size),
        .EX_mem_unsigned(EX_mem_unsigned),
        .MEM_data(MEM_data), .MEM_vld(MEM_vld), .MEM_busy(MEM_busy),
        .MEM_misaligned(MEM_misaligned), .MEM_bus_err(MEM_bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rd,
                         input logic wr, input logic [1:0] sz, input logic uns);
        EX_alu_res = a; EX_mem_din = d; EX_mem_rd = rd; EX_mem_wr = wr;
        EX_mem_size = sz; EX_mem_unsigned = uns; EX_vld = 1'b1;
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        check("rst_data", MEM_data, 32'h0);
        check("rst_vld", {31'b0, MEM_vld}, 32'h0);
        check("rst_req", {31'b0, dmem_req}, 32'h0);
        check("rst_busy", {31'b0, MEM_busy}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // ALU passthrough
        issue(32'h1234_5678, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
        @(negedge clk);
        check("alu_data", MEM_data, 32'h1234_5678);
        check("alu_vld", {31'b0, MEM_vld}, 32'h1);
        check("alu_noreq", {31'b0, dmem_req}, 32'h0);
        EX_vld = 1'b0;
        @(negedge clk);
        check("idle_vld", {31'b0, MEM_vld}, 32'h0);
        check("idle_hold", MEM_data, 32'h1234_5678);

        // LB signed, ack on first request cycle
        dmem_rdata = 32'h80AA_BBCC; dmem_ack = 1'b1;
        issue(32'h0000_0103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        EX_vld = 1'b0;
        check("lb_req", {31'b0, dmem_req}, 32'h1);
        check("lb_be", {28'b0, dmem_be}, 32'h8);
        check("lb_addr", dmem_addr, 32'h0000_0100);
        check("lb_we", {31'b0, dmem_we}, 32'h0);
        check("lb_busy", {31'b0, MEM_busy}, 32'h1);
        @(negedge clk);
        dmem_ack = 1'b0;
        check("lb_data", MEM_data, 32'hFFFF_FF80);
        check("lb_vld", {31'b0, MEM_vld}, 32'h1);
        check("lb_reqdrop", {31'b0, dmem_req}, 32'h0);

        // LHU, ack in the fourth request cycle
        dmem_rdata = 32'hBEEF_0000;
        issue(32'h0000_0102, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1);
        busy_cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            EX_vld = 1'b0;
            if (MEM_busy) busy_cnt++;
            if (i == 4) dmem_ack = 1'b1;
        end
        check("lhu_be", {28'b0, dmem_be}, 32'hC);
        @(negedge clk);
        dmem_ack = 1'b0;
        check("lhu_busy4", busy_cnt, 32'd4);
        check("lhu_data", MEM_data, 32'h0000_BEEF);
        check("lhu_vld", {31'b0, MEM_vld}, 32'h1);
        check("lhu_idle", {31'b0, MEM_busy}, 32'h0);

        // SB
        issue(32'h0000_0101, 32'hDEAD_BEA5, 1'b0, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        EX_vld = 1'b0;
        check("sb_we", {31'b0, dmem_we}, 32'h1);
        check("sb_be", {28'b0, dmem_be}, 32'h2);
        check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        check("sb_addr", dmem_addr, 32'h0000_0100);
        check("sb_novld", {31'b0, MEM_vld}, 32'h0);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("sb_vld", {31'b0, MEM_vld}, 32'h1);
        check("sb_data", MEM_data, 32'h0000_0101);

        // SH upper half
        dmem_ack = 1'b1;
        issue(32'h0000_0202, 32'h1234_CAFE, 1'b0, 1'b1, 2'b01, 1'b0);
        @(negedge clk);
        EX_vld = 1'b0;
        check("sh_be", {28'b0, dmem_be}, 32'hC);
        check("sh_wdata", dmem_wdata, 32'hCAFE_CAFE);
        @(negedge clk);
        check("sh_data", MEM_data, 32'h0000_0202);

        // LW and LH signed, back to back with immediate ack
        dmem_rdata = 32'h1122_3344;
        issue(32'h0000_0104, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
        @(negedge clk);
        EX_vld = 1'b0;
        check("lw_be", {28'b0, dmem_be}, 32'hF);
        @(negedge clk);
        check("lw_data", MEM_data, 32'h1122_3344);
        dmem_rdata = 32'h0000_8001;
        issue(32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0);
        @(negedge clk);
        EX_vld = 1'b0;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("lh_data", MEM_data, 32'hFFFF_8001);

        // Misaligned LW, reserved size, rd&wr both set
        issue(32'h0000_0102, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
        @(negedge clk);
        check("mis_flag", {31'b0, MEM_misaligned}, 32'h1);
        check("mis_noreq", {31'b0, dmem_req}, 32'h0);
        check("mis_busy", {31'b0, MEM_busy}, 32'h0);
        check("mis_vld", {31'b0, MEM_vld}, 32'h0);
        check("mis_hold", MEM_data, 32'hFFFF_8001);
        issue(32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0);
        @(negedge clk);
        check("sz11_flag", {31'b0, MEM_misaligned}, 32'h1);
        check("sz11_noreq", {31'b0, dmem_req}, 32'h0);
        issue(32'h0000_0100, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0);
        @(negedge clk);
        check("rdwr_flag", {31'b0, MEM_misaligned}, 32'h1);
        EX_vld = 1'b0;
        @(negedge clk);
        check("mis_pulse", {31'b0, MEM_misaligned}, 32'h0);

        // Reset while waiting
        issue(32'h0000_0300, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
        @(negedge clk);
        EX_vld = 1'b0;
        check("rw_req", {31'b0, dmem_req}, 32'h1);
        rst = 1'b0;
        #1;
        check("rw_reqdrop", {31'b0, dmem_req}, 32'h0);
        check("rw_busy", {31'b0, MEM_busy}, 32'h0);
        check("rw_data", MEM_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("rw_novld", {31'b0, MEM_vld}, 32'h0);

        // No-ack behaviour
        issue(32'h0000_0400, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
        busy_cnt = 0;
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            EX_vld = 1'b0;
            if (!MEM_busy) break;
            busy_cnt++;
        end
        check("tmo_cycles", busy_cnt, 32'd64);
        check("tmo_err", {31'b0, MEM_bus_err}, 32'h1);
        check("tmo_novld", {31'b0, MEM_vld}, 32'h0);
        check("tmo_hold", MEM_data, 32'h0);
        @(negedge clk);
        check("tmo_pulse", {31'b0, MEM_bus_err}, 32'h0);
`else
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            EX_vld = 1'b0;
            if (MEM_busy) busy_cnt++;
            if (MEM_bus_err) busy_cnt = 1000;
        end
        check("wait_persist", busy_cnt, 32'd80);
        dmem_rdata = 32'h5555_AAAA;
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("late_ack", MEM_data, 32'h5555_AAAA);
        check("late_err", {31'b0, MEM_bus_err}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
